triad_decode_bank: RTL and testbench
====================================

TRIAD_DECODE_BANK -- requirements
Module: triad_decode_bank

Interface
REQ-001 SHALL have parameter NCH, default 8, number of distrip channels (1..32).
REQ-002 SHALL have parameter PW, default 4, width of persist field.
REQ-003 SHALL have parameter CNTW, default 16, width of skip counter.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port _reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port soft_rst  input  1  synchronous reset of FSMs and counter (LCT reset).
REQ-007 SHALL have port persist  input  PW  halfstrip hold width in clocks; 0 treated as 1.
REQ-008 SHALL have port chan_en  input  NCH  per-channel enable.
REQ-009 SHALL have port distrip  input  NCH  serial triad stream, one bit per channel.
REQ-010 SHALL have port skip_cnt_rst  input  1  synchronous clear of skip_cnt.
REQ-011 SHALL have port halfstrips  output  4*NCH  decoded halfstrip hits; channel i owns bits [4i+3:4i].
REQ-012 SHALL have port triad_skip  output  NCH  one-clock skip pulse per channel.
REQ-013 SHALL have port skip_any  output  1  OR of triad_skip.
REQ-014 SHALL have port skip_cnt  output  CNTW  saturating count of skipped triads.
REQ-015 SHALL have port busy  output  NCH  channel not in IDLE.

Function
REQ-016 Each channel SHALL run FSM IDLE -> BIT1 -> BIT2 -> PERSIST -> IDLE.
REQ-017 IDLE: distrip[i]=1 with chan_en[i]=1 SHALL move to BIT1 and latch Peff = max(persist,1).
REQ-018 BIT1 SHALL capture distrip[i] as b1; BIT2 SHALL capture distrip[i] as b0; both SHALL advance unconditionally.
REQ-019 PERSIST SHALL assert exactly halfstrips[4i+{b1,b0}] for exactly Peff clocks; the other three bits SHALL be 0.
REQ-020 Latency: start bit sampled at edge t SHALL make the halfstrip high from edge t+3 through edge t+2+Peff.
REQ-021 On the last PERSIST clock the FSM SHALL return to IDLE; a start bit in the following cycle SHALL be accepted (back-to-back triads, no gap beyond 3+Peff clocks).
REQ-022 distrip[i]=1 during any PERSIST clock SHALL be ignored for decoding and SHALL pulse triad_skip[i] for one clock on the next edge.
REQ-023 A persist change mid-triad SHALL NOT affect the triad in flight (latched Peff used).
REQ-024 chan_en[i] deasserted in any state SHALL force IDLE on the next edge, zeroing that channel's halfstrips and busy; no skip SHALL be generated.
REQ-025 skip_cnt SHALL add popcount(triad_skip) each clock, saturating at 2^CNTW-1 (no wrap).
REQ-026 skip_cnt_rst and an increment in the same clock SHALL clear (clear wins).
REQ-027 soft_rst SHALL act as _reset for FSMs, outputs and skip_cnt, synchronously; it SHALL take priority over all other inputs.
REQ-028 All outputs SHALL be registered; no combinational path from distrip to any output.

Reset
REQ-029 _reset low SHALL asynchronously force all FSMs to IDLE, halfstrips=0, triad_skip=0, skip_any=0, skip_cnt=0, busy=0.
REQ-030 Release of _reset SHALL be synchronised so that the first accepted start bit is sampled no earlier than the second edge after deassertion.
REQ-031 Reset asserted mid-triad SHALL discard the triad without generating a skip.

Structure
REQ-032 FSM state encoding, state count and default parameter values SHALL live in the shared package triad_pkg.
REQ-033 One channel (FSM, b1/b0, Peff, persist counter, skip pulse) SHALL be sub-module triad_chan, instantiated NCH times by generate loop.
REQ-034 Popcount, saturating counter and skip_any SHALL be in triad_decode_bank top.

Verification
REQ-035 persist=5, ch0 stream 1,1,0 -> halfstrips[2]=1 for 5 clocks starting 3 clocks after start; other bits 0.
REQ-036 persist=0, ch3 stream 1,0,1 -> halfstrips[13]=1 for exactly 1 clock; persist=0 and persist=1 give identical waveforms.
REQ-037 persist=4, ch1 triad 1,0,0 then start bit 2 clocks into PERSIST -> triad_skip[1] one-clock pulse, skip_cnt=1, halfstrips[4] still exactly 4 clocks wide.
REQ-038 Skips on all 8 channels simultaneously with skip_cnt preset near 0xFFFC -> skip_cnt=0xFFFF, stays 0xFFFF; skip_cnt_rst same clock as skip -> 0.
REQ-039 Back-to-back triads ch2 (1,1,1 then 1,0,1 immediately after PERSIST ends) -> halfstrips[11] then halfstrips[9], no skip.
REQ-040 _reset asserted during BIT2 and chan_en dropped during PERSIST -> outputs 0 immediately/next edge, busy=0, skip_cnt unchanged by the abort.

Source files
------------

// File: rtl/triad_pkg.sv
// Shared definitions for the triad decoder bank: channel FSM encoding and default sizing.
package triad_pkg;

    localparam int unsigned TriadNumStates = 4;
    localparam int unsigned TriadStateW    = $clog2(TriadNumStates);

    localparam int unsigned NchDefault  = 8;
    localparam int unsigned PwDefault   = 4;
    localparam int unsigned CntwDefault = 16;

    typedef enum logic [TriadStateW-1:0] {
        StIdle    = 2'd0,
        StBit1    = 2'd1,
        StBit2    = 2'd2,
        StPersist = 2'd3
    } triad_state_e;

    function automatic logic [3:0] hs_onehot(input logic [1:0] code);
        hs_onehot = 4'b0001 << code;
    endfunction

endpackage

// File: rtl/triad_chan.sv
// One distrip channel: start bit plus two data bits select one of four halfstrips,
// which is then held for the latched persist width.
module triad_chan
    import triad_pkg::*;
#(
    parameter int unsigned PW = PwDefault
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          soft_rst,
    input  logic          en,
    input  logic          din,
    input  logic [PW-1:0] persist,
    output logic [3:0]    halfstrip,
    output logic          skip,
    output logic          busy
);

    triad_state_e  state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [1:0]    code_q, code_d;
    logic [3:0]    hs_q, hs_d;
    logic          skip_q, skip_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        hs_d    = '0;
        skip_d  = 1'b0;
        if (soft_rst || !en) begin
            state_d = StIdle;
            cnt_d   = '0;
            code_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (din) begin
                        state_d = StBit1;
                        cnt_d   = (persist == '0) ? PW'(1) : persist;
                    end
                end
                StBit1: begin
                    code_d[1] = din;
                    state_d   = StBit2;
                end
                StBit2: begin
                    code_d[0] = din;
                    state_d   = StPersist;
                end
                StPersist: begin
                    // Output lags the state by one clock, so the hit spans exactly cnt clocks.
                    hs_d   = hs_onehot(code_q);
                    skip_d = din;
                    if (cnt_q <= PW'(1)) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - PW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            code_q  <= '0;
            hs_q    <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            hs_q    <= hs_d;
            skip_q  <= skip_d;
        end
    end

    assign halfstrip = hs_q;
    assign skip      = skip_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: rtl/triad_decode_bank.sv
// Bank of NCH triad decoders with a shared saturating count of skipped triads.
module triad_decode_bank
    import triad_pkg::*;
#(
    parameter int unsigned NCH  = NchDefault,
    parameter int unsigned PW   = PwDefault,
    parameter int unsigned CNTW = CntwDefault
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             soft_rst,
    input  logic [PW-1:0]    persist,
    input  logic [NCH-1:0]   chan_en,
    input  logic [NCH-1:0]   distrip,
    input  logic             skip_cnt_rst,
    output logic [4*NCH-1:0] halfstrips,
    output logic [NCH-1:0]   triad_skip,
    output logic             skip_any,
    output logic [CNTW-1:0]  skip_cnt,
    output logic [NCH-1:0]   busy
);

    localparam int unsigned PopW = $clog2(NCH + 1);
    localparam int unsigned SumW = CNTW + 1;

    // Asynchronous assert, synchronous two-stage release.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        triad_chan #(
            .PW(PW)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .soft_rst (soft_rst),
            .en       (chan_en[i]),
            .din      (distrip[i]),
            .persist  (persist),
            .halfstrip(halfstrips[4*i +: 4]),
            .skip     (triad_skip[i]),
            .busy     (busy[i])
        );
    end

    logic [PopW-1:0] skip_pop;
    logic [SumW-1:0] cnt_sum;
    logic [CNTW-1:0] skip_cnt_q, skip_cnt_d;

    always_comb begin
        skip_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            skip_pop = skip_pop + PopW'(triad_skip[i]);
        end
    end

    always_comb begin
        cnt_sum    = {1'b0, skip_cnt_q} + SumW'(skip_pop);
        skip_cnt_d = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
        if (soft_rst || skip_cnt_rst) begin
            skip_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt_q <= '0;
        end else begin
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign skip_cnt = skip_cnt_q;
    assign skip_any = |triad_skip;

endmodule

// File: tb/tb_triad_decode_bank.sv
// Self-checking bench for triad_decode_bank: directed vectors plus random traffic vs a window model.
module tb_triad_decode_bank;

    localparam int NCH  = 8;
    localparam int PW   = 4;
    localparam int CNTW = 16;
    localparam int CMAX = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             soft_rst;
    logic [PW-1:0]    persist;
    logic [NCH-1:0]   chan_en;
    logic [NCH-1:0]   distrip;
    logic             skip_cnt_rst;
    logic [4*NCH-1:0] halfstrips;
    logic [NCH-1:0]   triad_skip;
    logic             skip_any;
    logic [CNTW-1:0]  skip_cnt;
    logic [NCH-1:0]   busy;

    always #5 clk = ~clk;

    triad_decode_bank #(
        .NCH (NCH),
        .PW  (PW),
        .CNTW(CNTW)
    ) dut (
        .clk         (clk),
        ._reset      (rst_b),
        .soft_rst    (soft_rst),
        .persist     (persist),
        .chan_en     (chan_en),
        .distrip     (distrip),
        .skip_cnt_rst(skip_cnt_rst),
        .halfstrips  (halfstrips),
        .triad_skip  (triad_skip),
        .skip_any    (skip_any),
        .skip_cnt    (skip_cnt),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Model: each channel remembers when its triad started; everything else is time windows.
    bit               m_act[NCH];
    int               m_ts[NCH];
    int               m_pe[NCH];
    logic [1:0]       m_code[NCH];
    logic [4*NCH-1:0] e_hs;
    logic [NCH-1:0]   e_skip;
    logic [NCH-1:0]   e_busy;
    int               e_cnt;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @edge %0d: got 0x%0h, want 0x%0h", name, n, a, e);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_act[i]  = 1'b0;
            m_code[i] = 2'b00;
        end
        e_hs   = '0;
        e_skip = '0;
        e_busy = '0;
        e_cnt  = 0;
    endtask

    task automatic model_edge();
        int pop;
        n++;
        if (soft_rst) begin
            model_clear();
            return;
        end
        pop = $countones(e_skip);
        if (skip_cnt_rst) e_cnt = 0;
        else e_cnt = (e_cnt + pop > CMAX) ? CMAX : e_cnt + pop;
        for (int i = 0; i < NCH; i++) begin
            bit d, win;
            d = distrip[i];
            e_hs[4*i +: 4] = '0;
            e_skip[i] = 1'b0;
            e_busy[i] = 1'b0;
            if (!chan_en[i]) begin
                m_act[i] = 1'b0;
                continue;
            end
            if (m_act[i] && n == m_ts[i] + 1) m_code[i][1] = d;
            if (m_act[i] && n == m_ts[i] + 2) m_code[i][0] = d;
            win = m_act[i] && n >= m_ts[i] + 3 && n <= m_ts[i] + 2 + m_pe[i];
            if (win) begin
                e_hs[4*i + int'(m_code[i])] = 1'b1;
                e_skip[i] = d;
            end
            if (m_act[i] && n > m_ts[i] + 2 + m_pe[i]) m_act[i] = 1'b0;
            if (!m_act[i] && d) begin
                m_act[i] = 1'b1;
                m_ts[i]  = n;
                m_pe[i]  = (persist == 0) ? 1 : int'(persist);
            end
            e_busy[i] = m_act[i] && (n < m_ts[i] + 2 + m_pe[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("halfstrips", 64'(halfstrips), 64'(e_hs));
        chk("triad_skip", 64'(triad_skip), 64'(e_skip));
        chk("skip_any", 64'(skip_any), 64'(|e_skip));
        chk("skip_cnt", 64'(skip_cnt), 64'(e_cnt));
        chk("busy", 64'(busy), 64'(e_busy));
    endtask

    task automatic do_soft_rst();
        soft_rst = 1'b1;
        distrip  = '0;
        step();
        soft_rst = 1'b0;
    endtask

    task automatic release_reset();
        distrip = '0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
    endtask

    // Start bit then two code bits on one channel, followed by idle clocks; traces the target bit.
    task automatic triad(input int ch, input logic [1:0] code_in, input int tail,
                         output logic [31:0] trace);
        int bit_idx;
        logic [2:0] s;
        bit_idx = 4*ch + int'(code_in);
        s = {1'b1, code_in};
        trace = '0;
        for (int k = 0; k < 3 + tail; k++) begin
            distrip = '0;
            if (k < 3) distrip[ch] = s[2-k];
            step();
            trace[k] = halfstrips[bit_idx];
        end
        distrip = '0;
    endtask

    typedef struct {
        logic       din;
        logic [3:0] hs;
        logic       bz;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        tbl[10];
        logic [31:0] tr0, tr1;
        logic [31:0] hs_tr, sk_tr;
        int          guard;

        rst_b        = 1'b0;
        soft_rst     = 1'b0;
        persist      = '0;
        chan_en      = '0;
        distrip      = '0;
        skip_cnt_rst = 1'b0;
        model_clear();

        #1;
        chk("rst_halfstrips", 64'(halfstrips), 64'd0);
        chk("rst_triad_skip", 64'(triad_skip), 64'd0);
        chk("rst_skip_any", 64'(skip_any), 64'd0);
        chk("rst_skip_cnt", 64'(skip_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Start bit on the first edge after release must be ignored.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b   = 1'b1;
        chan_en = '1;
        distrip = 8'h01;
        @(posedge clk);
        #1;
        distrip = '0;
        chk("sync_edge1_busy", 64'(busy), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("sync_busy", 64'(busy), 64'd0);
        end
        model_clear();

        // persist=5, ch0 code 10 -> bit 2 for 5 clocks, starting 3 clocks after start
        tbl[0] = '{1'b1, 4'h0, 1'b1};
        tbl[1] = '{1'b1, 4'h0, 1'b1};
        tbl[2] = '{1'b0, 4'h0, 1'b1};
        tbl[3] = '{1'b0, 4'h4, 1'b1};
        tbl[4] = '{1'b0, 4'h4, 1'b1};
        tbl[5] = '{1'b0, 4'h4, 1'b1};
        tbl[6] = '{1'b0, 4'h4, 1'b1};
        tbl[7] = '{1'b0, 4'h4, 1'b0};
        tbl[8] = '{1'b0, 4'h0, 1'b0};
        tbl[9] = '{1'b0, 4'h0, 1'b0};
        do_soft_rst();
        persist = 4'd5;
        for (int k = 0; k < 10; k++) begin
            distrip    = '0;
            distrip[0] = tbl[k].din;
            step();
            chk($sformatf("tbl%0d_hs", k), 64'(halfstrips[3:0]), 64'(tbl[k].hs));
            chk($sformatf("tbl%0d_others", k), 64'(halfstrips[31:4]), 64'd0);
            chk($sformatf("tbl%0d_busy", k), 64'(busy[0]), 64'(tbl[k].bz));
        end

        // persist 0 behaves as 1
        do_soft_rst();
        persist = 4'd0;
        triad(3, 2'b01, 7, tr0);
        persist = 4'd1;
        triad(3, 2'b01, 7, tr1);
        chk("persist0_trace", 64'(tr0), 64'h8);
        chk("persist0_vs_1", 64'(tr0), 64'(tr1));

        // Start bit inside PERSIST becomes a skip; hit width unchanged
        do_soft_rst();
        persist = 4'd4;
        hs_tr = '0;
        sk_tr = '0;
        for (int k = 0; k < 11; k++) begin
            distrip    = '0;
            distrip[1] = (k == 0 || k == 4);
            if (k == 1) persist = 4'd9;
            step();
            hs_tr[k] = halfstrips[4];
            sk_tr[k] = triad_skip[1];
        end
        chk("skip_hs4_trace", 64'(hs_tr), 64'h78);
        chk("skip_pulse_trace", 64'(sk_tr), 64'h10);
        chk("skip_cnt_one", 64'(skip_cnt), 64'd1);

        // Back-to-back triads on ch2 with no gap
        do_soft_rst();
        persist = 4'd2;
        triad(2, 2'b11, 2, tr0);
        triad(2, 2'b01, 4, tr1);
        chk("b2b_first_hs11", 64'(tr0), 64'h18);
        chk("b2b_second_hs9", 64'(tr1), 64'h18);
        chk("b2b_no_skip", 64'(skip_cnt), 64'd0);

        // chan_en drop during PERSIST aborts without a skip
        do_soft_rst();
        persist = 4'd3;
        for (int k = 0; k < 13; k++) begin
            distrip    = '0;
            chan_en    = '1;
            distrip[4] = (k == 0 || k == 3);
            distrip[5] = (k == 7 || k == 8 || k == 11);
            if (k == 11) chan_en[5] = 1'b0;
            step();
            if (k == 11) begin
                chk("endrop_busy5", 64'(busy[5]), 64'd0);
                chk("endrop_hs5", 64'(halfstrips[23:20]), 64'd0);
                chk("endrop_skip5", 64'(triad_skip[5]), 64'd0);
            end
        end
        chk("endrop_cnt", 64'(skip_cnt), 64'd1);

        // Async reset during BIT2 clears outputs at once
        distrip    = '0;
        distrip[0] = 1'b1;
        step();
        step();
        #3;
        rst_b = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hs", 64'(halfstrips), 64'd0);
        chk("arst_cnt", 64'(skip_cnt), 64'd0);
        chk("arst_skip", 64'({skip_any, triad_skip}), 64'd0);
        release_reset();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            persist      = PW'($urandom_range(0, 15));
            chan_en      = '1;
            distrip      = '0;
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 15) == 0) chan_en[i] = 1'b0;
                if ($urandom_range(0, 2) == 0) distrip[i] = 1'b1;
            end
            soft_rst     = ($urandom_range(0, 199) == 0);
            skip_cnt_rst = ($urandom_range(0, 49) == 0);
            step();
        end
        soft_rst     = 1'b0;
        skip_cnt_rst = 1'b0;

        // Saturation with all channels skipping
        do_soft_rst();
        chan_en = '1;
        persist = 4'd15;
        distrip = '1;
        guard   = 0;
        while (e_cnt < CMAX && guard < 20000) begin
            step();
            guard++;
        end
        chk("sat_reach_bound", 64'(guard < 20000), 64'd1);
        chk("sat_reached", 64'(skip_cnt), 64'(CMAX));
        repeat (40) step();
        chk("sat_held", 64'(skip_cnt), 64'(CMAX));
        guard = 0;
        while ($countones(e_skip) == 0 && guard < 50) begin
            step();
            guard++;
        end
        chk("clr_pending_skip", 64'(triad_skip != '0), 64'd1);
        skip_cnt_rst = 1'b1;
        step();
        skip_cnt_rst = 1'b0;
        chk("clr_wins", 64'(skip_cnt), 64'd0);
        distrip = '0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
